ms_delay_timer: RTL

MS_DELAY_TIMER -- requirements
Module: ms_delay_timer

---
 rtl/ms_timer_pkg.sv | 19 +
 rtl/Timer_1ms.sv | 35 +++
 rtl/variable_timer_top.sv | 49 ++++
 rtl/ms_delay_timer.sv | 69 ++++++
 4 files changed

// File: rtl/ms_timer_pkg.sv
// Shared definitions for the millisecond timer slice: state encoding and default widths.
// No logic; imported by the delay timer and its wrapper.
// No flow control.
package ms_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DW_DEFAULT          = 16;
    localparam int CLKS_PER_MS_DEFAULT = 50000;

    // Counter width that still works for a divide-by-one tick generator.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/Timer_1ms.sv
// Free-running ms tick generator: one-cycle tick every CLKS_PER_MS clocks while enabled.
// Latency: first tick CLKS_PER_MS clocks after enable rises; tick is registered.
// No backpressure; dropping enable clears the phase so each run starts a fresh ms.
module Timer_1ms
    import ms_timer_pkg::*;
#(
    parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = cnt_width(CLKS_PER_MS);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(CLKS_PER_MS - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/variable_timer_top.sv
// Delay timer paired with its ms tick generator; the generator only runs while timing.
// Latency: as ms_delay_timer, with ticks every CLKS_PER_MS clocks once busy.
// No backpressure.
module variable_timer_top
    import ms_timer_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          periodic,
    input  logic [DW-1:0] delay_ms,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] remaining
);

    logic tick_enable;
    logic ms_tick;

    Timer_1ms #(
        .CLKS_PER_MS(CLKS_PER_MS)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .enable(tick_enable),
        .tick  (ms_tick)
    );

    ms_delay_timer #(
        .DW(DW)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .periodic   (periodic),
        .delay_ms   (delay_ms),
        .ms_tick    (ms_tick),
        .tick_enable(tick_enable),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining)
    );

endmodule

// File: rtl/ms_delay_timer.sv
// Millisecond delay timer counting upstream ms ticks, one-shot or auto-reload.
// Latency: state/remaining/done update on the edge after start, abort or ms_tick is sampled.
// No backpressure; abort beats start beats ms_tick, and ticks are ignored while idle.
module ms_delay_timer
    import ms_timer_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          periodic,
    input  logic [DW-1:0] delay_ms,
    input  logic          ms_tick,
    output logic          tick_enable,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] remaining
);

    state_t        state;
    logic [DW-1:0] reload;
    logic          mode;

    assign busy        = (state == RUN);
    assign tick_enable = (state == RUN);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            reload    <= '0;
            mode      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                remaining <= '0;
            end else if (start) begin
                // A zero delay expires immediately instead of entering RUN.
                if (delay_ms != '0) begin
                    reload    <= delay_ms;
                    mode      <= periodic;
                    remaining <= delay_ms;
                    state     <= RUN;
                end else begin
                    remaining <= '0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
            end else if (state == RUN && ms_tick) begin
                if (remaining > DW'(1)) begin
                    remaining <= remaining - DW'(1);
                end else begin
                    done <= 1'b1;
                    if (mode) begin
                        remaining <= reload;
                    end else begin
                        remaining <= '0;
                        state     <= IDLE;
                    end
                end
            end
        end
    end

endmodule
